// File: rtl/bcd_7seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_7seg_scan_driver                                                     |
// | Time-multiplexed N-digit BCD to 7-segment driver, double-buffered.       |
// | Option macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_7seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame,
    output logic                    invalid
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]      C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            C_SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF   = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    wrap_q, frame_q;

    logic                    w_cnt_tc;
    logic                    w_wrap;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_suppress;
    logic [NUM_DIGITS-1:0]   w_bad;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = 7'b1000000;
        endcase
    endfunction

    assign w_cnt_tc = (cnt_q == C_CNT_LAST);
    assign w_wrap   = w_cnt_tc && (idx_q == C_IDX_LAST);
    assign w_digit  = disp_q[{idx_q, 2'b00} +: 4];
    assign w_onehot = NUM_DIGITS'(1) << idx_q;

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_above[i]: digit i and every higher digit are zero.
    logic [NUM_DIGITS-1:0] w_zero_above;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign w_zero_above[gi] = (disp_q[4*NUM_DIGITS-1:4*gi] == '0);
    end
    assign w_suppress = (idx_q != '0) && w_zero_above[idx_q];
`else
    assign w_suppress = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_invalid
        assign w_bad[gi] = (disp_q[4*gi +: 4] > 4'd9);
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (w_cnt_tc) begin
            cnt_d = '0;
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        shadow_d = load ? bcd_in : shadow_q;
        // A load landing on the wrap cycle bypasses the shadow so it is not lost.
        disp_d = disp_q;
        if (w_wrap) begin
            disp_d = load ? bcd_in : shadow_q;
        end
        seg_d = (blank || w_suppress) ? C_SEG_OFF : (f_decode(w_digit) ^ C_SEG_OFF);
        an_d  = blank ? C_AN_OFF : (w_onehot ^ C_AN_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            disp_q   <= '0;
            seg_q    <= C_SEG_OFF;
            an_q     <= C_AN_OFF;
            wrap_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            wrap_q   <= w_wrap;
            frame_q  <= wrap_q;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign frame   = frame_q;
    assign invalid = |w_bad;

endmodule
`default_nettype wire

// File: tb/tb_bcd_7seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_7seg_scan_driver                                                  |
// | Self-checking bench: scan-position reference model, random stimulus.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bcd_7seg_scan_driver;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int NR = N * R;

    logic          clk, rst, load, blank;
    logic [15:0]   bcd_in;
    logic [6:0]    seg, seg_n;
    logic [N-1:0]  an, an_n;
    logic          frame, frame_n, invalid, invalid_n;

    int checks = 0;
    int fails  = 0;

    bcd_7seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .blank(blank),
        .seg(seg), .an(an), .frame(frame), .invalid(invalid)
    );

    bcd_7seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut_n (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .blank(blank),
        .seg(seg_n), .an(an_n), .frame(frame_n), .invalid(invalid_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position in the frame is simply edges-since-reset mod NR.
    int          m_n;
    int          m_pos;
    logic [15:0] m_shadow, m_disp;
    logic [6:0]  exp_seg;
    logic [N-1:0] exp_an;
    logic        exp_frame;
    logic        exp_inv;

    function automatic logic [6:0] seg_of(input logic [15:0] v, input int d);
        logic [15:0] upper;
        logic [3:0]  dig;
        upper = v >> (4 * d);
        dig   = upper[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && upper == 16'd0) return 7'b0000000;
`endif
        case (dig)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        for (int d = 0; d < N; d++) begin
            if (((v >> (4 * d)) & 16'hf) > 16'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    assign m_pos   = m_n % NR;
    assign exp_inv = any_bad(m_disp);

    always @(posedge clk) begin
        if (rst) begin
            m_n       <= 0;
            m_shadow  <= '0;
            m_disp    <= '0;
            exp_seg   <= '0;
            exp_an    <= '0;
            exp_frame <= 1'b0;
        end else begin
            exp_an    <= blank ? '0 : N'(1 << (m_pos / R));
            exp_seg   <= blank ? '0 : seg_of(m_disp, m_pos / R);
            exp_frame <= (m_pos == 0) && (m_n >= NR);
            m_shadow  <= load ? bcd_in : m_shadow;
            if (m_pos == NR - 1) m_disp <= load ? bcd_in : m_shadow;
            m_n       <= m_n + 1;
        end
    end

    logic [25:0] obs, exp_all;
    assign obs     = {seg, an, frame, invalid, seg_n, an_n, frame_n, invalid_n};
    assign exp_all = {exp_seg, exp_an, exp_frame, exp_inv, ~exp_seg, ~exp_an, exp_frame, exp_inv};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; bcd_in = '0; blank = 1'b0;
        tick(); tick();
        checks++;
        if ({seg, an, frame, invalid, seg_n, an_n} !== {7'h00, 4'h0, 1'b0, 1'b0, 7'h7f, 4'hf}) begin
            fails++;
            $display("FAIL reset_state got %h required %h", {seg, an, frame, invalid, seg_n, an_n},
                     {7'h00, 4'h0, 1'b0, 1'b0, 7'h7f, 4'hf});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({seg, an} !== {7'b0111111, 4'b0001}) begin
            fails++;
            $display("FAIL first_digit got seg=%b an=%b required seg=0111111 an=0001", seg, an);
        end
    endtask

    task automatic test_scan();
        int nframe;
        nframe = 0;
        load = 1'b1; bcd_in = 16'h1234;
        tick();
        load = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin
                fails++;
                $display("FAIL scan_model cyc=%0d got %h required %h", i, obs, exp_all);
            end
            if (i >= 16 && frame === 1'b1) nframe++;
            if (i >= 24) begin
                checks++;
                case (an)
                    4'b0001: if (seg !== 7'b1100110) begin fails++; $display("FAIL scan_d0 got %b required 1100110", seg); end
                    4'b0010: if (seg !== 7'b1001111) begin fails++; $display("FAIL scan_d1 got %b required 1001111", seg); end
                    4'b0100: if (seg !== 7'b1011011) begin fails++; $display("FAIL scan_d2 got %b required 1011011", seg); end
                    4'b1000: if (seg !== 7'b0000110) begin fails++; $display("FAIL scan_d3 got %b required 0000110", seg); end
                    default: begin fails++; $display("FAIL scan_onehot got an=%b required one-hot", an); end
                endcase
            end
        end
        checks++;
        if (nframe != 4) begin
            fails++;
            $display("FAIL frame_count got %0d required 4", nframe);
        end
    endtask

    task automatic test_midframe();
        bit found;
        for (int k = 0; k < NR && m_pos != 8; k++) tick();
        load = 1'b1; bcd_in = 16'h5678;
        tick();
        load = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL midframe_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
        for (int k = 0; k < NR && m_pos != 2; k++) tick();
        load = 1'b1; bcd_in = 16'h1111;
        tick();
        load = 1'b0;
        for (int k = 0; k < NR && m_pos != 6; k++) tick();
        load = 1'b1; bcd_in = 16'h2222;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL lastwins_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
        found = 1'b0;
        for (int k = 0; k < NR && !found; k++) begin
            if (an === 4'b0001) found = 1'b1; else tick();
        end
        checks++;
        if (!found || seg !== 7'b1011011) begin
            fails++;
            $display("FAIL last_load_wins got seg=%b an=%b required seg=1011011 an=0001", seg, an);
        end
    endtask

    task automatic test_wrap_load();
        bit found;
        for (int k = 0; k < NR && m_pos != NR - 1; k++) tick();
        load = 1'b1; bcd_in = 16'h00A9;
        tick();
        load = 1'b0;
        checks++;
        if (invalid !== 1'b1) begin fails++; $display("FAIL wrap_invalid got %b required 1", invalid); end
        found = 1'b0;
        for (int k = 0; k < NR && !found; k++) begin
            if (an === 4'b0010) found = 1'b1; else tick();
        end
        checks++;
        if (!found || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL wrap_dash got seg=%b an=%b required seg=1000000 an=0010", seg, an);
        end
        load = 1'b1; bcd_in = 16'h0009;
        tick();
        load = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL wrap_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
        checks++;
        if (invalid !== 1'b0) begin fails++; $display("FAIL invalid_clear got %b required 0", invalid); end
    endtask

    task automatic test_blank();
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL blank_model cyc=%0d got %h required %h", i, obs, exp_all); end
            checks++;
            if ({seg, an, seg_n, an_n} !== {7'h00, 4'h0, 7'h7f, 4'hf}) begin
                fails++;
                $display("FAIL blank_off got %h required %h", {seg, an, seg_n, an_n}, {7'h00, 4'h0, 7'h7f, 4'hf});
            end
        end
        blank = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL unblank_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
    endtask

    task automatic test_rst_mid();
        bit saw9;
        saw9 = 1'b0;
        for (int k = 0; k < NR && m_pos != 12; k++) tick();
        load = 1'b1; bcd_in = 16'h9999;
        tick();
        load = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({seg, an, frame, invalid} !== 13'h0) begin
            fails++;
            $display("FAIL rst_mid got %h required 0", {seg, an, frame, invalid});
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL rst_model cyc=%0d got %h required %h", i, obs, exp_all); end
            if (seg === 7'b1101111) saw9 = 1'b1;
        end
        checks++;
        if (saw9) begin fails++; $display("FAIL rst_discard got nine shown required never"); end
    endtask

    task automatic test_zero_digits();
        bit found;
        load = 1'b1; bcd_in = 16'h0040;
        tick();
        load = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL zeros_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
        found = 1'b0;
        for (int k = 0; k < NR && !found; k++) begin
            if (an === 4'b1000) found = 1'b1; else tick();
        end
        checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (!found || seg !== 7'b0000000) begin
            fails++; $display("FAIL zeros_d3 got seg=%b an=%b required seg=0000000 an=1000", seg, an);
        end
`else
        if (!found || seg !== 7'b0111111) begin
            fails++; $display("FAIL zeros_d3 got seg=%b an=%b required seg=0111111 an=1000", seg, an);
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < N; d++) begin
                v[4*d +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            if ($urandom % 3 == 0) v[15:8] = 8'h00;
            bcd_in = v;
            load   = ($urandom % 6 == 0);
            blank  = ($urandom % 12 == 0);
            rst    = ($urandom % 200 == 0);
            tick();
            checks++;
            if (obs !== exp_all) begin fails++; $display("FAIL random_model cyc=%0d got %h required %h", i, obs, exp_all); end
        end
        load = 1'b0; blank = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0;
        test_reset();
        test_scan();
        test_midframe();
        test_wrap_load();
        test_blank();
        test_rst_mid();
        test_zero_digits();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_7seg_scan_driver.md
# bcd_7seg_scan_driver

Parametrised multi-digit, time-multiplexed BCD to 7-segment display driver. Successor to the single-digit combinational decoder: it latches an N-digit packed BCD word, double-buffers it so the display never tears mid-frame, and scans one digit at a time onto shared segment lines with one-hot digit enables. It sits between the BCD value producers (counters, ALU result registers) and the board display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥1)
- REFRESH_DIV, 1000, clock cycles each digit stays enabled (≥1)
- SEG_ACTIVE_LOW, 0, 1 inverts seg outputs (common-anode panels)
- AN_ACTIVE_LOW, 0, 1 inverts an outputs
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  strobe: capture bcd_in this cycle
- bcd_in  input  4*NUM_DIGITS  packed BCD, digit 0 (least significant) in bits [3:0]
- blank  input  1  forces all segments and enables off while high
- seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}
- an  output  NUM_DIGITS  one-hot digit enable, bit i = digit i
- frame  output  1  one-cycle pulse when the scan wraps to digit 0
- invalid  output  1  high while any displayed digit is >9

## Operation
- Shadow register: load=1 copies bcd_in into shadow; multiple loads in one frame, last wins.
- Display buffer: updated from shadow only at frame wrap (idx NUM_DIGITS-1 → 0). If load=1 in the wrap cycle, bcd_in itself is committed (bypass).
- Refresh counter cnt: 0..REFRESH_DIV-1, width max(1,$clog2(REFRESH_DIV)). At terminal count cnt→0 and idx advances; idx wraps NUM_DIGITS-1 → 0. REFRESH_DIV=1: idx advances every cycle.
- Decode (active-high, before polarity parameter): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, 10–15=1000000 (dash, segment g only).
- an = one-hot(idx); seg = decode(display[idx]).
- blank=1: seg and an all inactive; cnt/idx keep running; load and commit still operate.
- invalid = OR over display digits of (digit >9); combinational from display buffer, unaffected by blank.
- NUM_DIGITS=1: idx fixed 0, wrap (and frame) every REFRESH_DIV cycles.

## Timing
- Reset values: cnt=0, idx=0, shadow=0, display=0, seg all inactive, an all inactive, frame=0, invalid=0.
- seg and an registered: reflect idx/display/blank of the previous cycle (1-cycle latency). First cycle after reset release, outputs stay inactive; next edge drives digit 0.
- frame registered, high for exactly the cycle in which outputs first show digit 0 of the new frame.
- Load to display latency: from the load edge until the next wrap edge, plus 1 cycle to seg; worst case NUM_DIGITS*REFRESH_DIV+1 cycles.
- invalid changes in the cycle after the commit edge.
- rst mid-frame: all state returns to reset values on that edge; pending shadow data is discarded.

## Configuration
- LEADING_ZERO_BLANK_EN defined: while displayed, digit i (i≥1) is blanked (seg inactive, an still asserted) if it and all higher digits are 0; digit 0 never blanked; invalid digits stop suppression.
- Undefined: all digits always decoded, zeros shown as 0.

## Test plan
- NUM_DIGITS=4, REFRESH_DIV=4, reset then load 0x1234 → after first wrap, an cycles 0001,0010,0100,1000 every 4 cycles; seg = 1100110,1001111,1011011,0000110; frame pulses every 16 cycles.
- Load 0x5678 mid-frame (idx=2) → remaining digits still show old value; new value appears from digit 0 of next frame only; loads 0x1111 then 0x2222 in same frame → 0x2222 displayed.
- Load 0x00A9 in wrap cycle → committed immediately; digit 1 shows 1000000, invalid=1 next cycle; then load 0x0009 → invalid=0 after next wrap.
- blank=1 for 10 cycles → seg/an inactive one cycle after assertion; idx continues, frame pulse timing unchanged; SEG_ACTIVE_LOW=1 → seg=1111111 while blanked.
- Assert rst at idx=3 with pending load 0x9999 → next cycle all outputs inactive, display=0, 0x9999 never shown.
- LEADING_ZERO_BLANK_EN, load 0x0040 → digits 3 and 2 segments off, digit 1 shows 1100110, digit 0 shows 0111111; without macro digits 3/2 show 0111111.
